// File: rtl/spi_readback_tx.sv
// SPI slave readback path: decodes the 16-bit frame header on SCLK rising edges
// and returns DEVICE_ID followed by the addressed register on MISO (falling edges).
module spi_readback_tx #(
    parameter int unsigned               BYTE_WIDTH    = 8,
    parameter int unsigned               NUM_REGISTERS = 10,
    parameter logic [BYTE_WIDTH-1:0]     DEVICE_ID     = 8'hD1,
    parameter logic [3:0]                CMD_READ      = 4'b0010,
    parameter logic [BYTE_WIDTH-1:0]     INVALID_BYTE  = 8'hEE
) (
    input  logic                                  spi_sclk_i,
    input  logic                                  rst_low_i,
    input  logic                                  spi_ss_i,
    input  logic                                  spi_mosi_i,
    input  logic [NUM_REGISTERS*BYTE_WIDTH-1:0]   regs_flat_i,
    output logic                                  spi_miso_o,
    output logic [BYTE_WIDTH-1:0]                 last_header_o,
    output logic [BYTE_WIDTH-1:0]                 read_count_o
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned REGS_W  = NUM_REGISTERS * BYTE_WIDTH;

    logic [CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
    logic [BYTE_WIDTH-1:0] hdr_shift_q,   hdr_shift_d;
    logic [BYTE_WIDTH-1:0] data_byte_q,   data_byte_d;
    logic [BYTE_WIDTH-1:0] last_header_q, last_header_d;
    logic [BYTE_WIDTH-1:0] read_count_q,  read_count_d;
    logic                  miso_q,        miso_d;

    logic [BYTE_WIDTH-1:0] header_c;
    logic [NIB_W-1:0]      cmd_c;
    logic [NIB_W-1:0]      addr_c;
    logic                  addr_ok_c;
    logic [BYTE_WIDTH-1:0] reg_sel_c;
    logic [2:0]            bit_idx_c;

    // Header as it will look once the current MOSI bit is shifted in
    always_comb begin
        header_c  = {hdr_shift_q[BYTE_WIDTH-2:0], spi_mosi_i};
        cmd_c     = header_c[BYTE_WIDTH-1 -: NIB_W];
        addr_c    = header_c[NIB_W-1:0];
        addr_ok_c = 32'(addr_c) < NUM_REGISTERS;
        reg_sel_c = BYTE_WIDTH'(regs_flat_i >> (32'(addr_c) * BYTE_WIDTH));
    end

    // Receive/decode next-state (rising-edge domain)
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        hdr_shift_d   = hdr_shift_q;
        data_byte_d   = data_byte_q;
        last_header_d = last_header_q;
        read_count_d  = read_count_q;
        if (!spi_ss_i) begin
            bit_cnt_d   = bit_cnt_q + CNT_W'(1);
            hdr_shift_d = header_c;
            if (bit_cnt_q == CNT_W'(7)) begin
                last_header_d = header_c;
                if (cmd_c == CMD_READ) begin
                    if (addr_ok_c) begin
                        data_byte_d  = reg_sel_c;
                        read_count_d = read_count_q + BYTE_WIDTH'(1);
                    end else begin
                        data_byte_d  = INVALID_BYTE;
                    end
                end else begin
                    data_byte_d = {BYTE_WIDTH{1'b1}};
                end
            end
        end
    end

    always_ff @(posedge spi_sclk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            bit_cnt_q     <= '0;
            hdr_shift_q   <= '0;
            data_byte_q   <= {BYTE_WIDTH{1'b1}};
            last_header_q <= '0;
            read_count_q  <= '0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            hdr_shift_q   <= hdr_shift_d;
            data_byte_q   <= data_byte_d;
            last_header_q <= last_header_d;
            read_count_q  <= read_count_d;
        end
    end

    // MISO launch: ID byte in the first half of the frame, data byte in the second
    always_comb begin
        bit_idx_c = 3'd7 - bit_cnt_q[2:0];
        miso_d    = miso_q;
        if (!spi_ss_i) begin
            miso_d = bit_cnt_q[3] ? data_byte_q[bit_idx_c] : DEVICE_ID[bit_idx_c];
        end
    end

    always_ff @(negedge spi_sclk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            miso_q <= 1'b1;
        end else begin
            miso_q <= miso_d;
        end
    end

    assign spi_miso_o    = spi_ss_i ? 1'b1 : miso_q;
    assign last_header_o = last_header_q;
    assign read_count_o  = read_count_q;

    logic unused_c;
    assign unused_c = ^{REGS_W};

endmodule
